// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
// Debounces N_BTN raw buttons against one shared sample-tick counter. Each
// clean press becomes a pending event. Pending events are offered one at a
// time, in round-robin order, over a valid/ready handshake.
// Optional build macro: BTN_REPEAT_EN adds per-button auto-repeat hold
// counters. A held button re-raises its event every REPEAT_TICKS ticks.

module btn_event_arbiter #(
  parameter int N_BTN        = 4,
  parameter int TICK_W       = 18,
  parameter int REPEAT_TICKS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         i_btn,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [$clog2(N_BTN)-1:0] o_idx,
  output logic [N_BTN-1:0]         o_pending,
  output logic                     o_overflow
);

  localparam int IDX_W = $clog2(N_BTN);

  typedef enum logic {IDLE, OFFER} state_t;

  if (N_BTN < 2 || TICK_W < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("btn_event_arbiter: N_BTN>=2, TICK_W>=1 and REPEAT_TICKS>=1 required");
  end

  logic [N_BTN-1:0]  sync_a;
  logic [N_BTN-1:0]  sync_b;
  logic [N_BTN-1:0]  h1;
  logic [N_BTN-1:0]  h0;
  logic [TICK_W-1:0] cnt;
  logic              tick;
  logic [N_BTN-1:0]  first_press;
  logic [N_BTN-1:0]  press;
  logic [N_BTN-1:0]  pending;
  logic [N_BTN-1:0]  accept_mask;
  logic [N_BTN-1:0]  coalesce;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  last_nxt;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  idx_nxt;
  logic              valid_nxt;
  state_t            state;
  state_t            state_nxt;

  // Two-flop synchroniser on every raw button bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= i_btn;
      sync_b <= sync_a;
    end
  end

  // Shared free-running sample-tick counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign tick = &cnt;

  // Two-deep sample history, shifted once per tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 <= '0;
      h0 <= '0;
    end else if (tick) begin
      h1 <= sync_b;
      h0 <= h1;
    end
  end

  // Press = second consecutive high sample following a low sample
  always_comb begin
    first_press = {N_BTN{tick}} & sync_b & h1 & ~h0;
  end

`ifdef BTN_REPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);

  logic [HOLD_W-1:0] hold [N_BTN];
  logic [N_BTN-1:0]  rep_press;

  // Repeat fires on the tick that would bring the hold count to REPEAT_TICKS
  always_comb begin
    rep_press = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      rep_press[i] = tick & sync_b[i] & h1[i] & ~first_press[i] &
                     (hold[i] == HOLD_W'(REPEAT_TICKS - 1));
    end
  end

  // Per-button hold counters: clear on press, low sample or repeat; count held ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) hold[i] <= '0;
    end else if (tick) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (first_press[i] | ~sync_b[i] | rep_press[i]) hold[i] <= '0;
        else if (h1[i])                                 hold[i] <= hold[i] + 1'b1;
      end
    end
  end

  // Merge first presses with auto-repeat events
  always_comb begin
    press = first_press | rep_press;
  end
`else
  // Only first presses raise events
  always_comb begin
    press = first_press;
  end
`endif

  // One-hot of the button whose event is accepted this cycle
  always_comb begin
    accept_mask = '0;
    if (o_valid && i_ready) accept_mask[o_idx] = 1'b1;
    coalesce = press & pending & ~accept_mask;
  end

  // Pending flags and sticky overflow; a press wins over a same-cycle accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      o_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~accept_mask) | press;
      if (|coalesce) o_overflow <= 1'b1;
    end
  end

  assign o_pending = pending;

  // Round-robin pick: first pending bit at or after last+1, wrapping
  always_comb begin
    sel = '0;
    for (int unsigned j = N_BTN; j >= 1; j--) begin
      int unsigned cand;
      cand = (32'(last) + j) % N_BTN;
      if (pending[IDX_W'(cand)]) sel = IDX_W'(cand);
    end
  end

  // Offer FSM next-state and output logic
  always_comb begin
    state_nxt = state;
    valid_nxt = o_valid;
    idx_nxt   = o_idx;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (|pending) begin
          idx_nxt   = sel;
          valid_nxt = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (i_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = o_idx;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Offer FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_idx   <= '0;
      last    <= IDX_W'(N_BTN - 1);
    end else begin
      state   <= state_nxt;
      o_valid <= valid_nxt;
      o_idx   <= idx_nxt;
      last    <= last_nxt;
    end
  end

endmodule
